// File: rtl/pc_redirect_arbiter.sv
// PC redirect sequencer: picks mret > irq > branch, holds the winner until the PC unit
// accepts it, then squashes wrong-path branches for FLUSH_CYCLES cycles.
module pc_redirect_arbiter #(
   parameter int XLEN         = 32,
   parameter int FLUSH_CYCLES = 2
) (
   input  logic            clk_i,
   input  logic            reset_i,
   input  logic            enable_design,
   input  logic            br_req_i,
   input  logic [XLEN-1:0] br_target_i,
   input  logic            irq_req_i,
   input  logic [XLEN-1:0] irq_vector_i,
   input  logic            mret_req_i,
   input  logic [XLEN-1:0] mepc_i,
   input  logic            pc_ready_i,
   output logic            redir_valid_o,
   output logic [1:0]      redir_kind_o,
   output logic [XLEN-1:0] redir_target_o,
   output logic            flush_o,
   output logic            busy_o,
   output logic [7:0]      drop_cnt_o
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_HOLD  = 2'd1,
      ST_FLUSH = 2'd2
   } state_t;

   localparam logic [1:0]      KIND_NONE  = 2'd0;
   localparam logic [1:0]      KIND_BR    = 2'd1;
   localparam logic [1:0]      KIND_IRQ   = 2'd2;
   localparam logic [1:0]      KIND_MRET  = 2'd3;
   localparam logic [3:0]      FLUSH_LOAD = 4'(FLUSH_CYCLES);
   localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

   state_t            state_r, state_nxt_s;
   logic [1:0]        kind_r, kind_nxt_s;
   logic [XLEN-1:0]   target_r, target_nxt_s;
   logic [3:0]        cnt_r, cnt_nxt_s;
   logic [7:0]        drop_r, drop_nxt_s;
   logic              valid_r, flush_r, busy_r;
   logic              valid_nxt_s, flush_nxt_s, busy_nxt_s;
   logic [1:0]        drop_add_s;
   logic [8:0]        drop_sum_s;
   logic [1:0]        n_req_s;
   logic [1:0]        req_kind_s, ctl_kind_s;
   logic [XLEN-1:0]   req_target_s, ctl_target_s;
   logic              any_req_s, ctl_req_s, ctl_drop_s;

   // Priority encoding of the raw requests; ctl_* is the irq/mret-only view used while squashing
   always_comb begin
      n_req_s    = {1'b0, br_req_i} + {1'b0, irq_req_i} + {1'b0, mret_req_i};
      any_req_s  = br_req_i | irq_req_i | mret_req_i;
      ctl_req_s  = irq_req_i | mret_req_i;
      ctl_drop_s = irq_req_i & mret_req_i;
      if (mret_req_i) begin
         ctl_kind_s   = KIND_MRET;
         ctl_target_s = mepc_i & ALIGN_MASK;
      end else if (irq_req_i) begin
         ctl_kind_s   = KIND_IRQ;
         ctl_target_s = irq_vector_i & ALIGN_MASK;
      end else begin
         ctl_kind_s   = KIND_NONE;
         ctl_target_s = {XLEN{1'b0}};
      end
      if (ctl_req_s) begin
         req_kind_s   = ctl_kind_s;
         req_target_s = ctl_target_s;
      end else if (br_req_i) begin
         req_kind_s   = KIND_BR;
         req_target_s = br_target_i & ALIGN_MASK;
      end else begin
         req_kind_s   = KIND_NONE;
         req_target_s = {XLEN{1'b0}};
      end
   end

   // State register and all registered outputs
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_r  <= ST_IDLE;
         kind_r   <= KIND_NONE;
         target_r <= {XLEN{1'b0}};
         cnt_r    <= 4'd0;
         drop_r   <= 8'd0;
         valid_r  <= 1'b0;
         flush_r  <= 1'b0;
         busy_r   <= 1'b0;
      end else begin
         state_r  <= state_nxt_s;
         kind_r   <= kind_nxt_s;
         target_r <= target_nxt_s;
         cnt_r    <= cnt_nxt_s;
         drop_r   <= drop_nxt_s;
         valid_r  <= valid_nxt_s;
         flush_r  <= flush_nxt_s;
         busy_r   <= busy_nxt_s;
      end
   end

   // Next-state logic; kind/target are zero whenever no redirect is held
   always_comb begin
      state_nxt_s  = state_r;
      kind_nxt_s   = kind_r;
      target_nxt_s = target_r;
      cnt_nxt_s    = cnt_r;
      drop_add_s   = 2'd0;
      if (enable_design) begin
         case (state_r)
            ST_IDLE: begin
               if (any_req_s) begin
                  state_nxt_s  = ST_HOLD;
                  kind_nxt_s   = req_kind_s;
                  target_nxt_s = req_target_s;
                  drop_add_s   = n_req_s - 2'd1;
               end else begin
                  drop_add_s = 2'd0;
               end
            end
            ST_HOLD: begin
               if (pc_ready_i && ctl_req_s) begin
                  // transfer plus irq/mret in the same cycle: re-enter HOLD immediately
                  kind_nxt_s   = ctl_kind_s;
                  target_nxt_s = ctl_target_s;
                  drop_add_s   = {1'b0, br_req_i} + {1'b0, ctl_drop_s};
               end else if (pc_ready_i) begin
                  state_nxt_s  = (FLUSH_LOAD == 4'd0) ? ST_IDLE : ST_FLUSH;
                  cnt_nxt_s    = FLUSH_LOAD;
                  kind_nxt_s   = KIND_NONE;
                  target_nxt_s = {XLEN{1'b0}};
                  drop_add_s   = {1'b0, br_req_i};
               end else if (req_kind_s > kind_r) begin
                  kind_nxt_s   = req_kind_s;
                  target_nxt_s = req_target_s;
                  drop_add_s   = n_req_s - 2'd1;
               end else begin
                  drop_add_s = n_req_s;
               end
            end
            ST_FLUSH: begin
               if (ctl_req_s) begin
                  state_nxt_s  = ST_HOLD;
                  kind_nxt_s   = ctl_kind_s;
                  target_nxt_s = ctl_target_s;
                  drop_add_s   = {1'b0, br_req_i} + {1'b0, ctl_drop_s};
               end else if (cnt_r <= 4'd1) begin
                  state_nxt_s = ST_IDLE;
                  cnt_nxt_s   = 4'd0;
                  drop_add_s  = {1'b0, br_req_i};
               end else begin
                  cnt_nxt_s  = cnt_r - 4'd1;
                  drop_add_s = {1'b0, br_req_i};
               end
            end
            default: begin
               state_nxt_s  = ST_IDLE;
               kind_nxt_s   = KIND_NONE;
               target_nxt_s = {XLEN{1'b0}};
               cnt_nxt_s    = 4'd0;
            end
         endcase
      end else begin
         drop_add_s = 2'd0;
      end
   end

   // Output decode from the next state, plus saturating drop counter
   always_comb begin
      valid_nxt_s = (state_nxt_s == ST_HOLD);
      flush_nxt_s = (state_nxt_s != ST_IDLE);
      busy_nxt_s  = (state_nxt_s != ST_IDLE);
      drop_sum_s  = {1'b0, drop_r} + {7'd0, drop_add_s};
      if (drop_sum_s[8]) begin
         drop_nxt_s = 8'd255;
      end else begin
         drop_nxt_s = drop_sum_s[7:0];
      end
   end

   assign redir_valid_o  = valid_r;
   assign redir_kind_o   = kind_r;
   assign redir_target_o = target_r;
   assign flush_o        = flush_r;
   assign busy_o         = busy_r;
   assign drop_cnt_o     = drop_r;

endmodule
